data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, meaning the number of 32-bit words of storage; it SHALL be a power of two.
REQ-002 Parameter WAIT_CYCLES, default 1, meaning the number of wait-state cycles inserted between request accept and response; the range SHALL be 0..15.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-005 Port MemReq, input, 1 bit: the processor data-port request strobe.
REQ-006 Port MemWrite, input, 1 bit: 1 = write, 0 = read; sampled with MemReq.
REQ-007 Port ALUResult, input, 32 bits: byte address; bits [1:0] SHALL be ignored (word-aligned access).
REQ-008 Port WriteData, input, 32 bits: write data.
REQ-009 Port byteEnable, input, 4 bits: byte lane enables; bit i qualifies WriteData[8i+7:8i].
REQ-010 Port ReadData, output, 32 bits: read data.
REQ-011 Port MemReady, output, 1 bit: single-cycle response/completion pulse.
REQ-012 Port MemErr, output, 1 bit: address error flag; it SHALL be present only when DMEM_ERR_EN is defined.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, WAIT and RESP.
REQ-014 In IDLE with MemReq=1, the block SHALL latch MemWrite, the word index ALUResult[31:2], WriteData and byteEnable at the clock edge.
REQ-015 On accept, the next state SHALL be WAIT with the counter loaded to WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise it SHALL be RESP.
REQ-016 In WAIT, the counter SHALL decrement each cycle, and the block SHALL enter RESP on the cycle after the counter reads 0.
REQ-017 In RESP, MemReady SHALL be 1 for exactly one cycle, after which the block SHALL return unconditionally to IDLE.
REQ-018 Latency from the accept edge to the MemReady cycle SHALL be WAIT_CYCLES+1 cycles; the minimum request-to-request spacing SHALL be WAIT_CYCLES+2 cycles.
REQ-019 MemReq and all request inputs SHALL be ignored in WAIT and RESP, and no request queueing SHALL occur.
REQ-020 For a write, only the enabled byte lanes of the addressed word SHALL be updated, committed at the edge ending RESP.
REQ-021 A write with byteEnable=4'b0000 SHALL leave memory unchanged but SHALL still complete with MemReady.
REQ-022 For a read, ReadData SHALL present the full addressed word during RESP, with byteEnable ignored.
REQ-023 ReadData SHALL hold its value until the next read RESP; writes SHALL NOT change ReadData.
REQ-024 A read accepted after a write's RESP SHALL return the newly written data.
REQ-025 Without DMEM_ERR_EN, the word index SHALL wrap modulo DEPTH_WORDS.

Reset
REQ-026 On reset=0, the block SHALL force, asynchronously: state=IDLE, counter=0, MemReady=0, ReadData=32'h0 and MemErr=0 (if present).
REQ-027 Memory array contents SHALL NOT be reset.
REQ-028 A reset asserted mid-transaction (in WAIT or RESP) SHALL discard the pending access, with no memory write and no MemReady pulse.
REQ-029 Reset release SHALL be synchronous to clk, and the first accept SHALL be possible on the first rising edge with reset=1.

Configuration
REQ-030 The feature SHALL be controlled by the macro DMEM_ERR_EN.
REQ-031 With DMEM_ERR_EN defined, a word index >= DEPTH_WORDS SHALL produce, in RESP, MemErr=1 together with MemReady=1; the write SHALL be suppressed and a read SHALL return ReadData=32'h0.
REQ-032 With DMEM_ERR_EN defined, MemErr SHALL be 0 in all other cycles.
REQ-033 With DMEM_ERR_EN not defined, the MemErr port and its logic SHALL be absent, and wrap-around per REQ-025 SHALL apply.

Verification
REQ-034 Full-word write then read: write addr 32'h10, data 32'hDEADBEEF, be 4'hF, then read 32'h10 -> ReadData=32'hDEADBEEF, with MemReady exactly 2 cycles after each accept (WAIT_CYCLES=1).
REQ-035 Byte-lane write: preload 32'h11223344 at 32'h20, write 32'hAABBCCDD with be 4'b0101 -> read returns 32'h11BB33DD.
REQ-036 Zero-wait and busy-ignore: WAIT_CYCLES=0 with MemReq held high -> MemReady every 2nd cycle; requests presented in RESP are not accepted.
REQ-037 Reset mid-WAIT: WAIT_CYCLES=3, write 32'hFFFFFFFF to 32'h0, assert reset in the 2nd WAIT cycle -> no MemReady, word 0 is unchanged, and ReadData=0.
REQ-038 Address boundary, DEPTH_WORDS=64: address 32'h100 -> without DMEM_ERR_EN aliases word 0; with DMEM_ERR_EN gives MemErr=1, ReadData=0 and no write.
REQ-039 be=4'b0000 write to 32'h8 -> MemReady pulses, and the word is unchanged on readback.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory behind a wait-state FSM.
// Ports: clk, reset (async, active-low); request MemReq, MemWrite,
//   ALUResult (byte address), WriteData, byteEnable; response ReadData,
//   MemReady (one-cycle pulse), and MemErr when DMEM_ERR_EN is defined.
// Define DMEM_ERR_EN to flag word indices >= DEPTH_WORDS instead of wrapping.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [3:0]  byteEnable,
    output logic [31:0] ReadData,
    output logic        MemReady
`ifdef DMEM_ERR_EN
    ,
    output logic        MemErr
`endif
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    if ((DEPTH_WORDS < 2) ||
        ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH_WORDS must be a power of two >= 2");
    end

    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    logic        wr_q;
    logic [29:0] idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [29:0] sel_idx;
    logic        sel_wr;
    logic        sel_oob;
    logic        oob_q;
    logic        go_resp;
    logic        commit;

    // With zero wait states the response is formed on the accept edge
    // itself, so the live request fields stand in for the latched ones.
    assign sel_idx = (state == IDLE) ? ALUResult[31:2] : idx_q;
    assign sel_wr  = (state == IDLE) ? MemWrite : wr_q;

`ifdef DMEM_ERR_EN
    assign sel_oob = (sel_idx >> AW) != 30'd0;
    assign oob_q   = (idx_q >> AW) != 30'd0;

    logic unused_bits;
    assign unused_bits = ^ALUResult[1:0];
`else
    // Upper index bits are dropped: addresses alias modulo DEPTH_WORDS.
    assign sel_oob = 1'b0;
    assign oob_q   = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{ALUResult[1:0], sel_idx[29:AW], idx_q[29:AW]};
`endif

    assign go_resp = ((state == IDLE) && MemReq && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (cnt == 4'd0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            MemReady <= 1'b0;
            ReadData <= 32'h0;
            wr_q     <= 1'b0;
            idx_q    <= 30'd0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
`ifdef DMEM_ERR_EN
            MemErr   <= 1'b0;
`endif
        end else begin
            MemReady <= 1'b0;
`ifdef DMEM_ERR_EN
            MemErr   <= 1'b0;
`endif
            if (go_resp) begin
                MemReady <= 1'b1;
`ifdef DMEM_ERR_EN
                MemErr   <= sel_oob;
`endif
                // Writes leave ReadData holding the last read word.
                if (!sel_wr) begin
                    ReadData <= sel_oob ? 32'h0 : mem[sel_idx[AW-1:0]];
                end
            end

            unique case (state)
                IDLE: begin
                    if (MemReq) begin
                        wr_q    <= MemWrite;
                        idx_q   <= ALUResult[31:2];
                        wdata_q <= WriteData;
                        be_q    <= byteEnable;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write commits on the edge that ends RESP; a reset in WAIT or RESP
    // forces state to IDLE first, so an aborted access never lands.
    assign commit = (state == RESP) && wr_q && !oob_q;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q[AW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench over three wait-state configs.
// Instances: 0 -> WAIT_CYCLES=1, 1 -> WAIT_CYCLES=0, 2 -> WAIT_CYCLES=3.
module tb_data_mem_responder;

    typedef struct {
        int          g;
        int          cyc;
        bit          chk;
        logic [31:0] rd;
        bit          e_err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  ben   [3];
    logic [31:0] rdata [3];
    logic        rdy   [3];
`ifdef DMEM_ERR_EN
    logic        err   [3];
`endif

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t me;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WC = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        data_mem_responder #(
            .DEPTH_WORDS(64),
            .WAIT_CYCLES(WC)
        ) u_dut (
            .clk        (clk),
            .reset      (rst_n[g]),
            .MemReq     (req[g]),
            .MemWrite   (we[g]),
            .ALUResult  (addr[g]),
            .WriteData  (wdata[g]),
            .byteEnable (ben[g]),
            .ReadData   (rdata[g]),
            .MemReady   (rdy[g])
`ifdef DMEM_ERR_EN
            ,
            .MemErr     (err[g])
`endif
        );
    end

    function automatic int wc_of(int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rdy[g] === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready dut=%0d cyc=%0d got=1 required=0",
                             g, cyc);
                end else begin
                    me = sb.pop_front();
                    chk32("resp_dut", g, me.g);
                    chk32("resp_cycle", cyc, me.cyc);
                    if (me.chk) chk32("read_data", rdata[g], me.rd);
`ifdef DMEM_ERR_EN
                    chk32("mem_err", {31'd0, err[g]}, {31'd0, me.e_err});
`endif
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL response_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        #1;
    endtask

    // Presents one request for a single cycle; expected ready cycle is
    // the request cycle plus WAIT_CYCLES+1.
    task automatic issue(int g, bit wr, logic [31:0] a, logic [31:0] d,
                         logic [3:0] be, bit chk, logic [31:0] rd, bit e);
        exp_t x;
        req[g]   = 1'b1;
        we[g]    = wr;
        addr[g]  = a;
        wdata[g] = d;
        ben[g]   = be;
        x.g      = g;
        x.cyc    = cyc + wc_of(g) + 1;
        x.chk    = chk;
        x.rd     = rd;
        x.e_err  = e;
        sb.push_back(x);
        @(negedge clk);
        #1;
        req[g] = 1'b0;
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        exp_t x;
        for (int g = 0; g < 3; g++) begin
            rst_n[g] = 1'b0;
            req[g]   = 1'b0;
            we[g]    = 1'b0;
            addr[g]  = 32'h0;
            wdata[g] = 32'h0;
            ben[g]   = 4'h0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk32("reset_rdata", rdata[g], 32'h0);
            chk32("reset_ready", {31'd0, rdy[g]}, 32'd0);
`ifdef DMEM_ERR_EN
            chk32("reset_err", {31'd0, err[g]}, 32'd0);
`endif
        end
        for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;

        // WAIT_CYCLES=1: first request on the first edge out of reset.
        issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h0, 0);
        issue(0, 0, 32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, 0);
        issue(0, 0, 32'h13, 32'h0, 4'h0, 1, 32'hDEADBEEF, 0);
        issue(0, 1, 32'h20, 32'h11223344, 4'hF, 1, 32'hDEADBEEF, 0);
        issue(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, 32'hDEADBEEF, 0);
        issue(0, 0, 32'h20, 32'h0, 4'h0, 1, 32'h11BB33DD, 0);
        issue(0, 1, 32'h8, 32'h87654321, 4'hF, 1, 32'h11BB33DD, 0);
        issue(0, 1, 32'h8, 32'hFFFFFFFF, 4'h0, 1, 32'h11BB33DD, 0);
        issue(0, 0, 32'h8, 32'h0, 4'hF, 1, 32'h87654321, 0);
        issue(0, 1, 32'h0, 32'h01020304, 4'hF, 1, 32'h87654321, 0);
`ifdef DMEM_ERR_EN
        issue(0, 1, 32'h100, 32'hCAFEF00D, 4'hF, 1, 32'h87654321, 1);
        issue(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h01020304, 0);
        issue(0, 0, 32'h100, 32'h0, 4'h0, 1, 32'h0, 1);
        issue(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h01020304, 0);
`else
        issue(0, 1, 32'h100, 32'hCAFEF00D, 4'hF, 1, 32'h87654321, 0);
        issue(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'hCAFEF00D, 0);
        issue(0, 0, 32'h100, 32'h0, 4'h0, 1, 32'hCAFEF00D, 0);
`endif

        // WAIT_CYCLES=0: MemReq held high; odd cycles fall in RESP.
        issue(1, 1, 32'h44, 32'h44444444, 4'hF, 1, 32'h0, 0);
        req[1] = 1'b1;
        we[1]  = 1'b1;
        ben[1] = 4'hF;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                addr[1]  = 32'h40 + 32'(4 * k);
                wdata[1] = 32'hA0000000 + 32'(k);
                x.g      = 1;
                x.cyc    = cyc + 1;
                x.chk    = 1;
                x.rd     = 32'h0;
                x.e_err  = 0;
                sb.push_back(x);
            end else begin
                addr[1]  = 32'h44;
                wdata[1] = 32'hBAD00000 + 32'(k);
            end
            @(negedge clk);
            #1;
        end
        req[1] = 1'b0;
        wait_idle();
        issue(1, 0, 32'h40, 32'h0, 4'h0, 1, 32'hA0000000, 0);
        issue(1, 0, 32'h44, 32'h0, 4'h0, 1, 32'h44444444, 0);
        issue(1, 0, 32'h48, 32'h0, 4'h0, 1, 32'hA0000002, 0);
        issue(1, 0, 32'h50, 32'h0, 4'h0, 1, 32'hA0000004, 0);

        // WAIT_CYCLES=3: reset during the second WAIT cycle.
        issue(2, 1, 32'h0, 32'h5A5A5A5A, 4'hF, 1, 32'h0, 0);
        issue(2, 0, 32'h0, 32'h0, 4'h0, 1, 32'h5A5A5A5A, 0);
        req[2]   = 1'b1;
        we[2]    = 1'b1;
        addr[2]  = 32'h0;
        wdata[2] = 32'hFFFFFFFF;
        ben[2]   = 4'hF;
        @(negedge clk);
        #1;
        req[2] = 1'b0;
        @(negedge clk);
        #1;
        rst_n[2] = 1'b0;
        #1;
        chk32("midwait_rst_rdata", rdata[2], 32'h0);
        chk32("midwait_rst_ready", {31'd0, rdy[2]}, 32'd0);
        @(negedge clk);
        #1;
        rst_n[2] = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        issue(2, 0, 32'h0, 32'h0, 4'h0, 1, 32'h5A5A5A5A, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
